// File: rtl/pipeline_pkg.sv
// Shared encodings for the MEM-stage / loader memory arbiter: FSM states,
// grant owner, and the latched access record.
package pipeline_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CPU_ACC = 2'd1,
        ST_DMA_ACC = 2'd2
    } arb_state_e;

    typedef enum logic {
        GRANT_CPU = 1'b0,
        GRANT_DMA = 1'b1
    } grant_e;

    typedef struct packed {
        logic              we;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_access_t;

    // On a tie the port that did not win last time gets the memory.
    function automatic grant_e pick_grant(input logic   cpu_req,
                                          input logic   dma_req,
                                          input grant_e last_grant);
        if (cpu_req && dma_req) begin
            if (last_grant == GRANT_DMA) return GRANT_CPU;
            else                         return GRANT_DMA;
        end else if (cpu_req) begin
            return GRANT_CPU;
        end else begin
            return GRANT_DMA;
        end
    endfunction

endpackage

// File: rtl/wait_counter.sv
// Down-counter timing one memory access: loaded on grant, counts to zero and
// parks there; o_zero marks the completion cycle.
module wait_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    // NOTE: clocked state is only ever updated with non-blocking assignments.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && !o_zero) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter between the MEM pipeline stage and a loader/debug port in
// front of a single data memory; one access at a time, IDLE between accesses.
module mem_arbiter
    import pipeline_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic [31:0] dma_rdata,
    output logic        dma_ack,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);

    arb_state_e  r_state;
    arb_state_e  w_next_state;
    grant_e      r_last_grant;
    grant_e      w_grant;
    logic        w_grant_valid;
    mem_access_t r_acc;
    mem_access_t w_winner;
    logic [31:0] r_cpu_rdata;
    logic [31:0] r_dma_rdata;
    logic        w_cnt_zero;
    logic        w_cpu_done;
    logic        w_dma_done;

    wait_counter #(
        .CNT_W(CNT_W)
    ) u_wait_counter (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_grant_valid),
        .i_load_val (LOAD_VAL),
        .i_dec      (r_state != ST_IDLE),
        .o_zero     (w_cnt_zero)
    );

    // NOTE: defaults first so no path through this block leaves a latch behind.
    always_comb begin
        w_next_state  = r_state;
        w_grant_valid = 1'b0;
        w_grant       = GRANT_CPU;
        w_winner      = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};

        case (r_state)
            ST_IDLE: begin
                if (cpu_req || dma_req) begin
                    w_grant_valid = 1'b1;
                    w_grant       = pick_grant(cpu_req, dma_req, r_last_grant);
                    if (w_grant == GRANT_CPU) begin
                        w_next_state = ST_CPU_ACC;
                    end else begin
                        w_next_state = ST_DMA_ACC;
                        w_winner     = '{we: dma_we, addr: dma_addr, wdata: dma_wdata};
                    end
                end
            end
            ST_CPU_ACC, ST_DMA_ACC: begin
                if (w_cnt_zero) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= GRANT_DMA;
            r_acc        <= '0;
            r_cpu_rdata  <= '0;
            r_dma_rdata  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_grant_valid) begin
                r_last_grant <= w_grant;
                r_acc        <= w_winner;
            end
            if (w_cpu_done) r_cpu_rdata <= mem_rdata;
            if (w_dma_done) r_dma_rdata <= mem_rdata;
        end
    end

    assign w_cpu_done = (r_state == ST_CPU_ACC) && w_cnt_zero;
    assign w_dma_done = (r_state == ST_DMA_ACC) && w_cnt_zero;

    // The write strobe exists only in the completion cycle: one edge per store.
    assign mem_we    = (w_cpu_done || w_dma_done) && r_acc.we;
    assign mem_addr  = r_acc.addr;
    assign mem_wdata = r_acc.wdata;

    assign cpu_stall = cpu_req && !w_cpu_done;
    assign cpu_rdata = w_cpu_done ? mem_rdata : r_cpu_rdata;
    assign dma_rdata = r_dma_rdata;
    assign dma_ack   = w_dma_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (WAIT_CYCLES 1 and 3) each in front of a
// small data memory, checked against a word-array model and latency formulas.
module tb_mem_arbiter;

    localparam int N_DUT = 2;

    logic        clk = 1'b0;
    logic        rst       [N_DUT];
    logic        cpu_req   [N_DUT];
    logic        cpu_we    [N_DUT];
    logic [31:0] cpu_addr  [N_DUT];
    logic [31:0] cpu_wdata [N_DUT];
    logic [31:0] cpu_rdata [N_DUT];
    logic        cpu_stall [N_DUT];
    logic        dma_req   [N_DUT];
    logic        dma_we    [N_DUT];
    logic [31:0] dma_addr  [N_DUT];
    logic [31:0] dma_wdata [N_DUT];
    logic [31:0] dma_rdata [N_DUT];
    logic        dma_ack   [N_DUT];
    logic        mem_we    [N_DUT];
    logic [31:0] mem_addr  [N_DUT];
    logic [31:0] mem_wdata [N_DUT];
    logic [31:0] mem_rdata [N_DUT];

    logic [31:0] mem     [N_DUT][64] = '{default: '0};
    logic [31:0] exp_mem [N_DUT][64];
    int          we_cnt  [N_DUT] = '{0, 0};
    int          ack_cnt [N_DUT] = '{0, 0};
    bit          last_dma[N_DUT];

    int          n_pass  = 0;
    int          n_fail  = 0;
    int          n_total = 0;
    logic [31:0] rd;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        mem_arbiter #(
            .WAIT_CYCLES (g == 0 ? 1 : 3),
            .CNT_W       (4)
        ) u_dut (
            .clk       (clk),
            .reset     (rst[g]),
            .cpu_req   (cpu_req[g]),
            .cpu_we    (cpu_we[g]),
            .cpu_addr  (cpu_addr[g]),
            .cpu_wdata (cpu_wdata[g]),
            .cpu_rdata (cpu_rdata[g]),
            .cpu_stall (cpu_stall[g]),
            .dma_req   (dma_req[g]),
            .dma_we    (dma_we[g]),
            .dma_addr  (dma_addr[g]),
            .dma_wdata (dma_wdata[g]),
            .dma_rdata (dma_rdata[g]),
            .dma_ack   (dma_ack[g]),
            .mem_we    (mem_we[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_rdata (mem_rdata[g])
        );
        assign mem_rdata[g] = mem[g][mem_addr[g][7:2]];
    end

    // Data memory with a combinational read port; also counts strobes.
    always @(posedge clk) begin
        for (int g = 0; g < N_DUT; g++) begin
            if (mem_we[g]) begin
                mem[g][mem_addr[g][7:2]] <= mem_wdata[g];
                we_cnt[g]                <= we_cnt[g] + 1;
            end
            if (dma_ack[g]) ack_cnt[g] <= ack_cnt[g] + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int wait_of(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int g, input bit is_dma, input bit req, input bit we,
                         input logic [31:0] a, input logic [31:0] d);
        if (is_dma) begin
            dma_req[g] = req; dma_we[g] = we; dma_addr[g] = a; dma_wdata[g] = d;
        end else begin
            cpu_req[g] = req; cpu_we[g] = we; cpu_addr[g] = a; cpu_wdata[g] = d;
        end
    endtask

    // One uncontended access; request inputs are scrambled after the grant
    // edge, so only the values presented in IDLE may reach the memory.
    task automatic single(input int g, input bit is_dma, input bit we,
                          input logic [31:0] addr, input logic [31:0] data,
                          output logic [31:0] rdata);
        int          lat;
        int          w0;
        int          a0;
        int          wd;
        logic [31:0] exp_rd;
        wd     = int'(addr[7:2]);
        exp_rd = exp_mem[g][wd];
        w0     = we_cnt[g];
        a0     = ack_cnt[g];
        lat    = -1;
        rdata  = '0;
        drive(g, is_dma, 1'b1, we, addr, data);
        for (int c = 0; c < 40; c++) begin
            #1;
            if (is_dma ? dma_ack[g] : !cpu_stall[g]) begin
                lat = c;
                if (!is_dma) rdata = cpu_rdata[g];
                break;
            end
            step();
            drive(g, is_dma, 1'b1, ~we, ~addr, ~data);
        end
        step();
        drive(g, is_dma, 1'b0, 1'b0, '0, '0);
        #1;
        if (is_dma) rdata = dma_rdata[g];
        check(is_dma ? "dma_latency" : "cpu_latency", lat, wait_of(g));
        check("we_pulses", we_cnt[g] - w0, {31'd0, we});
        check("ack_pulses", ack_cnt[g] - a0, {31'd0, is_dma});
        if (!we) check(is_dma ? "dma_load_data" : "cpu_load_data", rdata, exp_rd);
        if (!is_dma && !we) check("cpu_rdata_hold", cpu_rdata[g], rdata);
        if (we) exp_mem[g][wd] = data;
        last_dma[g] = is_dma;
    endtask

    // Both ports hold load requests; completions must alternate starting with
    // the port that did not win last, spaced one full access plus turnaround.
    task automatic contend(input int g, input int n_ev);
        logic [31:0] ca;
        logic [31:0] da;
        int          k;
        int          w;
        bit          exp_dma;
        bit          pend;
        ca      = 32'($urandom_range(0, 15)) << 2;
        da      = 32'($urandom_range(0, 15)) << 2;
        w       = wait_of(g);
        k       = 0;
        pend    = 1'b0;
        exp_dma = !last_dma[g];
        drive(g, 1'b0, 1'b1, 1'b0, ca, '0);
        drive(g, 1'b1, 1'b1, 1'b0, da, '0);
        for (int c = 0; c < 200 && k < n_ev; c++) begin
            #1;
            if (pend) begin
                check("cont_dma_rdata", dma_rdata[g], exp_mem[g][da[7:2]]);
                pend = 1'b0;
            end
            if (!cpu_stall[g] || dma_ack[g]) begin
                check("cont_cpu_done", {31'd0, !cpu_stall[g]}, {31'd0, !exp_dma});
                check("cont_dma_ack", {31'd0, dma_ack[g]}, {31'd0, exp_dma});
                check("cont_cycle", c, k * (w + 1) + w);
                if (!exp_dma) check("cont_cpu_rdata", cpu_rdata[g], exp_mem[g][ca[7:2]]);
                pend        = exp_dma;
                last_dma[g] = exp_dma;
                exp_dma     = !exp_dma;
                k++;
            end
            step();
            if (k == n_ev) begin
                drive(g, 1'b0, 1'b0, 1'b0, '0, '0);
                drive(g, 1'b1, 1'b0, 1'b0, '0, '0);
            end
        end
        check("cont_events", k, n_ev);
        if (pend) begin
            #1;
            check("cont_dma_rdata", dma_rdata[g], exp_mem[g][da[7:2]]);
        end
    endtask

    initial begin
        logic [31:0] d;
        int          wd;
        int          w0;
        int          a0;

        for (int g = 0; g < N_DUT; g++) begin
            rst[g]      = 1'b1;
            last_dma[g] = 1'b1;
            drive(g, 1'b0, 1'b0, 1'b0, '0, '0);
            drive(g, 1'b1, 1'b0, 1'b0, '0, '0);
            for (int i = 0; i < 64; i++) exp_mem[g][i] = '0;
        end

        step();
        step();
        cpu_req[0] = 1'b1;
        #1;
        for (int g = 0; g < N_DUT; g++) begin
            check("rst_cpu_rdata", cpu_rdata[g], '0);
            check("rst_dma_rdata", dma_rdata[g], '0);
            check("rst_mem_addr", mem_addr[g], '0);
            check("rst_mem_wdata", mem_wdata[g], '0);
            check("rst_mem_we", {31'd0, mem_we[g]}, '0);
            check("rst_dma_ack", {31'd0, dma_ack[g]}, '0);
        end
        check("rst_stall_req", {31'd0, cpu_stall[0]}, 32'd1);
        check("rst_stall_idle", {31'd0, cpu_stall[1]}, 32'd0);
        cpu_req[0] = 1'b0;
        rst[0]     = 1'b0;
        rst[1]     = 1'b0;
        step();

        // Simultaneous requests from reset: CPU first, DMA two cycles later.
        contend(0, 2);

        single(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, rd);
        single(0, 1'b0, 1'b0, 32'h10, 32'h0, rd);
        check("cpu_reload", rd, 32'hDEADBEEF);

        single(0, 1'b1, 1'b1, 32'h4, 32'h12345678, rd);
        single(0, 1'b1, 1'b0, 32'h4, 32'h0, rd);
        check("dma_reload", rd, 32'h12345678);

        single(1, 1'b0, 1'b1, 32'h20, 32'hA5A5_0F0F, rd);
        single(1, 1'b0, 1'b0, 32'h20, 32'h0, rd);

        // Reset during a DMA store while the counter reads 1.
        wd = 9;
        d  = ~exp_mem[1][wd];
        w0 = we_cnt[1];
        a0 = ack_cnt[1];
        drive(1, 1'b1, 1'b1, 1'b1, 32'(wd) << 2, d);
        step();
        step();
        rst[1] = 1'b1;
        drive(1, 1'b1, 1'b0, 1'b0, '0, '0);
        #1;
        check("midrst_mem_we", {31'd0, mem_we[1]}, '0);
        check("midrst_dma_ack", {31'd0, dma_ack[1]}, '0);
        check("midrst_mem_addr", mem_addr[1], '0);
        check("midrst_dma_rdata", dma_rdata[1], '0);
        step();
        step();
        rst[1]      = 1'b0;
        last_dma[1] = 1'b1;
        for (int i = 0; i < 64; i++) exp_mem[1][i] = mem[1][i];
        step();
        check("midrst_we_pulses", we_cnt[1] - w0, '0);
        check("midrst_acks", ack_cnt[1] - a0, '0);
        check("midrst_word", mem[1][wd], ~d);

        single(1, 1'b0, 1'b0, 32'(wd) << 2, 32'h0, rd);
        contend(1, 3);
        contend(0, 4);

        for (int i = 0; i < 24; i++) begin
            single(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   32'($urandom_range(0, 15)) << 2, $urandom, rd);
        end
        contend(1, 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1: memory access cycles per transfer; legal range 1..15.
REQ-002 SHALL have parameter CNT_W, default 4: wait-counter width.
REQ-003 clk  in  1  single clock; all state changes on posedge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 cpu_req  in  1  MEM-stage access request (load or store).
REQ-006 cpu_we  in  1  MEM-stage write enable (MemWrite).
REQ-007 cpu_addr, cpu_wdata  in  32 each  MEM-stage address and store data.
REQ-008 cpu_rdata  out  32  load data to MEM/WB.
REQ-009 cpu_stall  out  1  freeze pipeline while high.
REQ-010 dma_req, dma_we  in  1 each  loader/debug port request and write enable.
REQ-011 dma_addr, dma_wdata  in  32 each  loader address and data.
REQ-012 dma_rdata  out  32; dma_ack  out  1  loader data and one-cycle completion pulse.
REQ-013 mem_we  out  1; mem_addr, mem_wdata  out  32  to the data memory.
REQ-014 mem_rdata  in  32  combinational read data from the data memory.

Function
REQ-015 FSM states: IDLE, CPU_ACC, DMA_ACC.
REQ-016 In IDLE, a request from only one port moves the FSM to that port's ACC state on the next edge.
REQ-017 In IDLE with both requests, grant goes to the port not recorded in last_grant; last_grant updates on every grant.
REQ-018 On entry to an ACC state: latch the winner's addr/wdata/we; load cnt with WAIT_CYCLES-1.
REQ-019 In ACC, mem_addr/mem_wdata are the latched values; cnt decrements each cycle while non-zero.
REQ-020 The completion cycle is the ACC cycle with cnt==0; mem_we equals the latched we in that cycle only, else 0, giving exactly one write edge per store.
REQ-021 After the completion cycle the FSM always returns to IDLE (one-cycle turnaround); no ACC-to-ACC transition.
REQ-022 cpu_stall is high whenever cpu_req is high and the FSM is not in the CPU_ACC completion cycle; otherwise low.
REQ-023 In the CPU_ACC completion cycle, cpu_rdata equals mem_rdata; in other cycles it holds the value captured at the last CPU completion.
REQ-024 dma_ack is high only in the DMA_ACC completion cycle; dma_rdata is captured from mem_rdata at that edge.
REQ-025 Requesters hold req/addr/wdata/we stable until completion; changes after the latch edge are ignored.
REQ-026 CPU load/store latency is WAIT_CYCLES+1 cycles from first cpu_req cycle (IDLE) to completion cycle with no contention.
REQ-027 With contention, either port waits at most one foreign access (WAIT_CYCLES+1 cycles) plus its own.
REQ-028 In IDLE, mem_we is 0 and mem_addr/mem_wdata hold their last values.

Reset
REQ-029 Reset asserted at any time, including mid-access, forces IDLE, cnt=0, mem_we=0, dma_ack=0, last_grant=DMA (CPU wins the first tie), and cpu_rdata, dma_rdata, mem_addr and mem_wdata to 0.
REQ-030 An access interrupted by reset performs no write and is not acknowledged.

Structure
REQ-031 State encoding (IDLE/CPU_ACC/DMA_ACC) and grant encoding (CPU/DMA) SHALL live in a shared package, pipeline_pkg.
REQ-032 The wait counter SHALL be a sub-module, wait_counter (load, decrement, zero flag).
REQ-033 The existing data memory instance connects to mem_* unchanged; the arbiter sits between it and stageMEM.

Verification
REQ-034 WAIT_CYCLES=1, cpu store addr 0x10, data 0xDEADBEEF -> stall 1 cycle, single mem_we pulse; later load 0x10 returns 0xDEADBEEF in the completion cycle.
REQ-035 WAIT_CYCLES=3, cpu load -> cpu_stall high exactly 3 cycles, low in the 4th with valid cpu_rdata.
REQ-036 cpu_req and dma_req asserted together from reset -> CPU served first; dma_ack appears 2 cycles after CPU completion (WAIT_CYCLES=1).
REQ-037 Both requests held continuously -> grants alternate CPU, DMA, CPU; neither port waits beyond one foreign access.
REQ-038 Reset pulsed during a DMA_ACC store at cnt=1 -> no mem_we pulse, no dma_ack, FSM in IDLE, target memory word unchanged.
REQ-039 dma write 0x00000004 <- 0x12345678, then dma read 0x4 -> dma_rdata 0x12345678 with one dma_ack per access.
